// File: rtl/register_bank_dispatcher.sv
// Command-stream dispatcher: decodes one header beat per command and forwards
// its payload to one register-bank stream, draining and counting bad commands.
//
// Ports:
//   aclk, resetn         clock, synchronous active-low reset
//   s_axis_*             shared command stream in (tvalid/tready/tlast/tdata)
//   m_axis_tvalid[B]     per-bank valid (one-hot or zero)
//   m_axis_tready[B]     per-bank ready (only the held bank's bit is used)
//   m_axis_tlast/tdata   shared payload out, one-entry output register
//   busy                 FSM not idle or output register occupied
//   drop_count           saturating count of drained/aborted commands
module register_bank_dispatcher #(
    parameter int NUM_BANKS        = 4,
    parameter int CMD_STREAM_WIDTH = 32,
    parameter int LEN_WIDTH        = 16
) (
    input  logic                        aclk,
    input  logic                        resetn,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        s_axis_tlast,
    input  logic [CMD_STREAM_WIDTH-1:0] s_axis_tdata,
    output logic [NUM_BANKS-1:0]        m_axis_tvalid,
    input  logic [NUM_BANKS-1:0]        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic [CMD_STREAM_WIDTH-1:0] m_axis_tdata,
    output logic                        busy,
    output logic [15:0]                 drop_count
);
    localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] NB_LIM   = 8'(NUM_BANKS);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAYLOAD,
        S_DRAIN
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [LEN_WIDTH-1:0]          r_remaining;
    logic [LEN_WIDTH-1:0]          w_rem_nxt;
    logic [BW-1:0]                 r_bank;
    logic [BW-1:0]                 w_bank_nxt;
    logic                          r_out_full;
    logic [BW-1:0]                 r_out_bank;
    logic [CMD_STREAM_WIDTH-1:0]   r_out_data;
    logic                          r_out_last;
    logic [15:0]                   r_drop_count;

    logic                          w_tready;
    logic                          w_load;
    logic                          w_load_last;
    logic                          w_drop;
    logic                          w_out_ready;
    logic [NUM_BANKS-1:0]          w_tvalid;
    logic [7:0]                    w_hdr_op;
    logic [7:0]                    w_hdr_bank;
    logic [LEN_WIDTH-1:0]          w_hdr_len;

    assign w_hdr_op    = s_axis_tdata[31:24];
    assign w_hdr_bank  = s_axis_tdata[23:16];
    assign w_hdr_len   = s_axis_tdata[LEN_WIDTH-1:0];
    // Ready is taken from the bank of the beat actually held, so a new
    // command for another bank waits until the old beat leaves.
    assign w_out_ready = m_axis_tready[r_out_bank];

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_remaining;
        w_bank_nxt  = r_bank;
        w_tready    = 1'b0;
        w_load      = 1'b0;
        w_load_last = 1'b0;
        w_drop      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_tready = 1'b1;
                if (s_axis_tvalid) begin
                    if (w_hdr_len == '0) begin
                        w_drop = (w_hdr_op != OP_WRITE);
                    end else if (s_axis_tlast) begin
                        w_drop = 1'b1;
                    end else if (w_hdr_op == OP_WRITE && w_hdr_bank < NB_LIM) begin
                        w_state_nxt = S_PAYLOAD;
                        w_rem_nxt   = w_hdr_len;
                        w_bank_nxt  = w_hdr_bank[BW-1:0];
                    end else begin
                        w_state_nxt = S_DRAIN;
                        w_rem_nxt   = w_hdr_len;
                        w_drop      = 1'b1;
                    end
                end
            end
            S_PAYLOAD: begin
                w_tready = !r_out_full || w_out_ready;
                if (s_axis_tvalid && w_tready) begin
                    w_load      = 1'b1;
                    w_load_last = (r_remaining == LEN_ONE) || s_axis_tlast;
                    w_rem_nxt   = r_remaining - LEN_ONE;
                    if (r_remaining == LEN_ONE) begin
                        w_state_nxt = S_IDLE;
                    end else if (s_axis_tlast) begin
                        w_state_nxt = S_IDLE;
                        w_drop      = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                w_tready = 1'b1;
                if (s_axis_tvalid) begin
                    w_rem_nxt = r_remaining - LEN_ONE;
                    if (r_remaining == LEN_ONE || s_axis_tlast) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            r_remaining  <= '0;
            r_bank       <= '0;
            r_out_full   <= 1'b0;
            r_out_bank   <= '0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_remaining <= w_rem_nxt;
            r_bank      <= w_bank_nxt;
            // A load in the same cycle as a drain keeps the register full.
            if (w_load) begin
                r_out_full <= 1'b1;
                r_out_bank <= r_bank;
                r_out_data <= s_axis_tdata;
                r_out_last <= w_load_last;
            end else if (r_out_full && w_out_ready) begin
                r_out_full <= 1'b0;
            end
            if (w_drop && r_drop_count != 16'hFFFF) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    always_comb begin
        w_tvalid = '0;
        if (r_out_full) begin
            w_tvalid[r_out_bank] = 1'b1;
        end
    end

    assign s_axis_tready = w_tready;
    assign m_axis_tvalid = w_tvalid;
    assign m_axis_tlast  = r_out_last;
    assign m_axis_tdata  = r_out_data;
    assign busy          = (r_state != S_IDLE) || r_out_full;
    assign drop_count    = r_drop_count;
endmodule
